comar_rand_gen: RTL and testbench
=================================

COMAR_RAND_GEN -- requirements
Module: comar_rand_gen

Interface
REQ-001 Parameter R_W, default 6, SHALL set the width of the fresh-mask output r; legal range 1..32.
REQ-002 Parameter WARMUP, default 64, SHALL set the number of warm-up cycles after seeding; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 seed_valid  input  1  SHALL indicate that seed carries a new seed.
REQ-006 seed  input  32  SHALL carry the LFSR seed value.
REQ-007 seed_ready  output  1  SHALL indicate the block accepts a seed this cycle.
REQ-008 en  input  1  SHALL request a fresh mask word each cycle while in RUN.
REQ-009 r  output  R_W  SHALL be the registered fresh-mask word driving the r bus of downstream COMAR gadgets.
REQ-010 r_valid  output  1  SHALL be high only when r holds post-warm-up randomness.

Function
REQ-011 The block SHALL hold a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1; one step: fb = s[31]^s[21]^s[1]^s[0], s' = {s[30:0], fb}.
REQ-012 Each advance SHALL apply R_W unrolled steps in one cycle; r SHALL load bits [R_W-1:0] of the advanced state in the same edge.
REQ-013 FSM states SHALL be UNSEEDED, WARM and RUN; reset state UNSEEDED.
REQ-014 seed_ready SHALL be 1 in every state while rst is low, and 0 while rst is high.
REQ-015 Handshake: seed is accepted in any cycle with seed_valid=1 and seed_ready=1; next edge loads the LFSR with seed, or with 32'h0000_0001 if seed==0, clears the warm-up counter and enters WARM.
REQ-016 In WARM, the LFSR SHALL advance every cycle regardless of en; the counter increments; the edge on which the counter equals WARMUP-1 SHALL also move the FSM to RUN.
REQ-017 r_valid SHALL equal (state==RUN); first r_valid=1 is WARMUP+1 cycles after the handshake cycle.
REQ-018 In RUN with en=1 the LFSR and r SHALL advance every cycle; with en=0 both SHALL hold, and r_valid SHALL stay 1.
REQ-019 In UNSEEDED the LFSR, counter and r SHALL hold; en SHALL be ignored.
REQ-020 A seed accepted in WARM or RUN SHALL take priority over stepping, reload the LFSR, restart warm-up, and drop r_valid from the next edge.
REQ-021 r SHALL never change while r_valid=1 and en=0.

Reset
REQ-022 On rst high, state SHALL go to UNSEEDED, LFSR to 0, counter to 0, r to 0 and r_valid to 0 immediately, without waiting for clk.
REQ-023 Reset asserted mid-WARM or mid-RUN SHALL discard the seed; a new handshake is required after release.
REQ-024 A seed_valid present in the first cycle after rst release SHALL be accepted.

Structure
REQ-025 Package comar_rand_pkg SHALL hold the FSM state typedef, the 32-bit LFSR width constant, the tap constant and the zero-seed substitute constant.
REQ-026 One sub-module, comar_lfsr_step, SHALL implement the combinational R_W-step advance (parameter R_W); the top holds all registers.

Verification
REQ-027 R_W=6, WARMUP=1: rst, release, seed=32'h1 with seed_valid for one cycle -> r_valid=1 two cycles after the handshake cycle, r=6'h2D, LFSR=32'h6D.
REQ-028 Same config, seed=32'h0 -> identical response to seed 32'h1 (r=6'h2D); the LFSR never reaches 0.
REQ-029 WARMUP=64: handshake -> r_valid stays 0 for exactly 64 cycles, rises in cycle 65; r changes every WARM cycle.
REQ-030 RUN, en toggling 1,0,0,1 -> r advances, holds two cycles, advances; r_valid stays 1 throughout.
REQ-031 RUN, new seed accepted -> r_valid=0 from the next edge for WARMUP cycles; the output sequence restarts from the new seed.
REQ-032 rst pulsed asynchronously mid-RUN between clock edges -> r=0, r_valid=0 immediately; block remains UNSEEDED with en=1 until a new seed.

Source files
------------

// File: rtl/comar_rand_pkg.sv
// Shared types and constants for the COMAR fresh-mask generator.
// LFSR taps: x^32 + x^22 + x^2 + x + 1.
package comar_rand_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    WARM     = 2'd1,
    RUN      = 2'd2
  } state_t;

  localparam int               LFSR_W        = 32;
  // Feedback bits s[31], s[21], s[1], s[0].
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 32'h8020_0003;
  // An all-zero state would lock the LFSR, so seed 0 is swapped for this.
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

endpackage

// File: rtl/comar_rand_gen_if.sv
// Seed handshake and fresh-mask output bus of comar_rand_gen.
interface comar_rand_gen_if #(
  parameter int R_W = 6
);
  logic           seed_valid;
  logic [31:0]    seed;
  logic           seed_ready;
  logic           en;
  logic [R_W-1:0] r;
  logic           r_valid;

  modport master (
    output seed_valid, seed, en,
    input  seed_ready, r, r_valid
  );

  modport slave (
    input  seed_valid, seed, en,
    output seed_ready, r, r_valid
  );
endinterface

// File: rtl/comar_lfsr_step.sv
// Combinational R_W-step advance of the 32-bit Fibonacci LFSR.
module comar_lfsr_step
  import comar_rand_pkg::*;
#(
  parameter int R_W = 6
) (
  input  logic [LFSR_W-1:0] s,
  output logic [LFSR_W-1:0] s_nxt
);

  always_comb begin
    s_nxt = s;
    for (int i = 0; i < R_W; i++)
      s_nxt = {s_nxt[LFSR_W-2:0], ^(s_nxt & LFSR_TAPS)};
  end

endmodule

// File: rtl/comar_rand_gen.sv
// Fresh-mask generator: seeded LFSR, fixed warm-up, then R_W new bits per enabled cycle.
module comar_rand_gen
  import comar_rand_pkg::*;
#(
  parameter int R_W    = 6,
  parameter int WARMUP = 64
) (
  input  logic             clk,
  input  logic             rst,
  comar_rand_gen_if.slave  bus
);

  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [7:0]        cnt;
  logic [R_W-1:0]    r_q;
  logic              r_valid_q;
  logic              seed_fire;

  assign bus.seed_ready = ~rst;
  assign seed_fire      = bus.seed_valid & bus.seed_ready;
  assign bus.r          = r_q;
  assign bus.r_valid    = r_valid_q;

  comar_lfsr_step #(.R_W(R_W)) u_step (
    .s     (lfsr),
    .s_nxt (lfsr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNSEEDED;
      lfsr      <= '0;
      cnt       <= '0;
      r_q       <= '0;
      r_valid_q <= 1'b0;
    end else if (seed_fire) begin
      // A new seed always wins over stepping and restarts warm-up.
      lfsr      <= (bus.seed == '0) ? ZERO_SEED_SUB : bus.seed;
      cnt       <= '0;
      state     <= WARM;
      r_valid_q <= 1'b0;
    end else begin
      case (state)
        UNSEEDED: ;
        WARM: begin
          lfsr <= lfsr_nxt;
          r_q  <= lfsr_nxt[R_W-1:0];
          cnt  <= cnt + 8'd1;
          if (cnt == WARM_LAST) begin
            state     <= RUN;
            r_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.en) begin
            lfsr <= lfsr_nxt;
            r_q  <= lfsr_nxt[R_W-1:0];
          end
        end
        default: begin
          state     <= UNSEEDED;
          r_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comar_rand_gen.sv
// Directed bench for comar_rand_gen: short warm-up instance plus a WARMUP=64 instance.
module tb_comar_rand_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comar_rand_gen_if #(.R_W(6)) b1 ();
  comar_rand_gen_if #(.R_W(6)) b64 ();

  comar_rand_gen #(.R_W(6), .WARMUP(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  comar_rand_gen #(.R_W(6), .WARMUP(64)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int lows;
  int k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b1.seed_valid  = 1'b0; b1.seed  = '0; b1.en  = 1'b0;
    b64.seed_valid = 1'b0; b64.seed = '0; b64.en = 1'b0;
    #3;
    chk("rst_ready", b1.seed_ready, 0);
    chk("rst_r",     b1.r,          0);
    chk("rst_valid", b1.r_valid,    0);
    tick(); tick();

    // Seed in the very first cycle after release.
    rst = 1'b0;
    b1.seed_valid = 1'b1; b1.seed = 32'h0000_0001;
    #1 chk("ready_up", b1.seed_ready, 1);
    tick();
    b1.seed_valid = 1'b0;
    chk("s1_warm_valid", b1.r_valid,    0);
    chk("s1_warm_lfsr",  u_dut1.lfsr,   32'h1);
    tick();
    chk("s1_r",     b1.r,        6'h2D);
    chk("s1_valid", b1.r_valid,  1);
    chk("s1_lfsr",  u_dut1.lfsr, 32'h6D);

    // Zero seed behaves like seed 1; reseed in RUN drops r_valid.
    b1.seed_valid = 1'b1; b1.seed = 32'h0;
    tick();
    b1.seed_valid = 1'b0;
    chk("s0_drop",      b1.r_valid,  0);
    chk("s0_lfsr_sub",  u_dut1.lfsr, 32'h1);
    tick();
    chk("s0_r",     b1.r,        6'h2D);
    chk("s0_valid", b1.r_valid,  1);
    chk("s0_lfsr",  u_dut1.lfsr, 32'h6D);

    // Seed with bit 21 set so r differs on every advance; then en 1,0,0,1.
    b1.seed_valid = 1'b1; b1.seed = 32'h0020_0000;
    tick();
    b1.seed_valid = 1'b0;
    chk("sb_drop", b1.r_valid, 0);
    tick();
    chk("sb_r0",    b1.r,        6'h36);
    chk("sb_lfsr0", u_dut1.lfsr, 32'h0800_0036);
    b1.en = 1'b1; tick();
    chk("en1_r",     b1.r,       6'h35);
    chk("en1_lfsr",  u_dut1.lfsr, 32'h0000_0DB5);
    b1.en = 1'b0; tick();
    chk("en0a_r",     b1.r,       6'h35);
    chk("en0a_valid", b1.r_valid, 1);
    tick();
    chk("en0b_r",     b1.r,       6'h35);
    chk("en0b_valid", b1.r_valid, 1);
    b1.en = 1'b1; tick();
    chk("en1b_r",     b1.r,       6'h2D);
    chk("en1b_valid", b1.r_valid, 1);

    // Asynchronous reset pulse between edges while running with en=1.
    #3 rst = 1'b1;
    #1;
    chk("ar_r",     b1.r,          0);
    chk("ar_valid", b1.r_valid,    0);
    chk("ar_ready", b1.seed_ready, 0);
    chk("ar_lfsr",  u_dut1.lfsr,   0);
    #1 rst = 1'b0;
    tick(); tick(); tick();
    chk("uns_r",     b1.r,        0);
    chk("uns_valid", b1.r_valid,  0);
    chk("uns_lfsr",  u_dut1.lfsr, 0);
    b1.en = 1'b0;

    // Fresh handshake after reset works again.
    b1.seed_valid = 1'b1; b1.seed = 32'h0000_0001;
    tick();
    b1.seed_valid = 1'b0;
    tick();
    chk("rs_r",     b1.r,       6'h2D);
    chk("rs_valid", b1.r_valid, 1);

    // WARMUP=64: r_valid low for 64 sampled cycles after the handshake edge.
    chk("w64_idle_r", b64.r, 0);
    b64.seed_valid = 1'b1; b64.seed = 32'h0020_0000;
    tick();
    b64.seed_valid = 1'b0;
    lows = 0;
    k    = 1;
    while (!b64.r_valid && k <= 100) begin
      if (k == 2) chk("w64_r2", b64.r, 6'h36);
      if (k == 3) chk("w64_r3", b64.r, 6'h35);
      if (k == 4) chk("w64_r4", b64.r, 6'h2D);
      lows++;
      tick();
      k++;
    end
    chk("w64_len",   lows,          64);
    chk("w64_valid", b64.r_valid,   1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
